change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4, giving the number of cycles coin_out is held high per eject attempt (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50, giving the cycles to wait for a coin-sensed edge after a pulse ends (legal range 1..1023).
REQ-003 SHALL have parameter MAX_RETRY, default 2, giving the eject attempts allowed per coin before jam (legal range 1..7).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port change, input, 2 bits: change request code, 00=none, 01=5, 10=10, 11=reserved (ignored); a request is a one-cycle code.
REQ-007 SHALL have port coin_sensed, input, 1 bit: hopper exit sensor, asynchronous to clk, high while a coin passes.
REQ-008 SHALL have port clear_jam, input, 1 bit: one-cycle jam acknowledge.
REQ-009 SHALL have port coin_out, output, 1 bit: hopper eject drive that ejects one 5-unit coin per pulse.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a request completes.
REQ-012 SHALL have port jam, output, 1 bit: sticky hopper fault indication.
REQ-013 SHALL have port req_drop, output, 1 bit: one-cycle pulse when a request is lost.

Function
REQ-014 SHALL implement states IDLE, PULSE, WAIT, DONE and JAM.
REQ-015 SHALL decode code 01 to remaining=1 coin and code 10 to remaining=2 coins, held in a 2-bit remaining counter.
REQ-016 SHALL, in IDLE with a valid code at edge N, enter PULSE with coin_out high from edge N+1 for exactly PULSE_CYCLES cycles, then enter WAIT.
REQ-017 SHALL pass coin_sensed through a 2-flop synchronizer and rising-edge detector, so an edge registers 3 cycles after the pin rises.
REQ-018 SHALL count a detected edge in PULSE or WAIT as one coin: decrement remaining, clear the retry count, and if remaining becomes 0 enter DONE, otherwise enter PULSE (next coin).
REQ-019 SHALL, in PULSE, finish the full pulse after a counted edge before moving on.
REQ-020 SHALL, when the WAIT timer reaches TIMEOUT_CYCLES with no edge, increment the retry count and re-enter PULSE if retry < MAX_RETRY, otherwise enter JAM.
REQ-021 SHALL ignore detected edges in IDLE, DONE and JAM.
REQ-022 SHALL assert done for the single DONE cycle, then go to IDLE, or directly to PULSE if the pending slot is full.
REQ-023 SHALL provide a one-deep pending slot that captures a valid code arriving while busy and the slot is empty.
REQ-024 SHALL pulse req_drop when a valid code arrives while busy and the slot is full, or at any time in JAM.
REQ-025 SHALL, in JAM, hold jam=1 and coin_out=0, discard the pending slot, and return to IDLE on clear_jam; clear_jam outside JAM has no effect.
REQ-026 SHALL drive coin_out, done and req_drop from registers, with no combinational path from inputs.

Reset
REQ-027 SHALL, while reset is low, force state=IDLE, coin_out=0, busy=0, done=0, jam=0, req_drop=0, clear all counters and synchronizer flops, and empty the pending slot, including mid-pulse.

Configuration
REQ-028 SHALL, with CHANGE_DISP_STATS_EN defined, add output coins_total (16 bits, wraps at 65535->0, reset 0) that increments per counted coin, and output jam_count (8 bits, saturates at 255) that increments on entry to JAM.
REQ-029 SHALL, without CHANGE_DISP_STATS_EN, omit these ports and their logic entirely.

Structure
REQ-030 SHALL place the coin codes (NONE, C5, C10) and the state encoding in shared package vend_pkg, for reuse by vending_machine-side logic.
REQ-031 SHALL place the synchronizer plus rising-edge detector in sub-module edge_sync.

Verification
REQ-032 SHALL cover: change=01 at edge 10, sensor pulse during WAIT -> coin_out high for cycles 11..14, one coin counted, done pulses once, busy falls.
REQ-033 SHALL cover: change=10 with a sensor pulse after each eject -> two 4-cycle coin_out pulses, done after the second coin, coins_total=2 when the macro is defined.
REQ-034 SHALL cover: change=01 with the sensor held low -> 2 pulses each followed by 50 WAIT cycles, then JAM with jam=1; clear_jam -> IDLE, jam=0.
REQ-035 SHALL cover: change=10 while busy, then change=01 while the slot is full -> first request queued and served after done, second request gives a one-cycle req_drop.
REQ-036 SHALL cover: reset low in the middle of PULSE -> coin_out=0 immediately (asynchronously), all outputs at reset values, pending slot discarded.
REQ-037 SHALL cover: change=11 and sensor pulses while IDLE -> no state change and no outputs.

Source files
------------

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the change dispenser and the vending-machine side
// logic that issues change requests.
//   coin_e  : change request codes carried on the 2-bit change bus
//   state_e : change dispenser FSM state encoding
//   coins_for_code / is_valid_code : decode a request code into a coin count
// ---------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    C5   = 2'b01,
    C10  = 2'b10,
    RSVD = 2'b11
  } coin_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    JAM   = 3'd4
  } state_e;

  // Number of 5-unit coins needed for a request; 0 means "not a request".
  function automatic logic [1:0] coins_for_code(input logic [1:0] code);
    case (code)
      C5:      return 2'd1;
      C10:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_valid_code(input logic [1:0] code);
    return (code == C5) || (code == C10);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer followed by a rising-edge detector for a signal that
// is asynchronous to clk. A rise on async_in shows up on rise during the
// cycle after the second synchronizer flop captures it, so the consuming
// FSM acts on it at the third clock edge after the pin rises.
// Ports:
//   clk      : clock
//   reset    : asynchronous active-low reset
//   async_in : raw asynchronous input
//   rise     : one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Drives a coin hopper to pay out 5 or 10 units of change as one or two
// 5-unit coins. Each coin is ejected by a PULSE_CYCLES-long pulse on
// coin_out; the hopper exit sensor confirms each coin. A coin that is not
// sensed within TIMEOUT_CYCLES after its pulse is retried, and after
// MAX_RETRY unsuccessful attempts the block latches a jam until clear_jam.
// One further request may be queued while busy; extra requests are dropped.
//
// Optional feature macro: CHANGE_DISP_STATS_EN adds coins_total (wrapping
// count of coins paid) and jam_count (saturating count of jams).
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   change      : request code (00 none, 01 = 5, 10 = 10, 11 ignored)
//   coin_sensed : hopper exit sensor, asynchronous
//   clear_jam   : jam acknowledge, only effective in JAM
//   coin_out    : hopper eject drive (registered)
//   busy        : state is not IDLE
//   done        : one-cycle pulse when a request completes (registered)
//   jam         : hopper fault, held until clear_jam
//   req_drop    : one-cycle pulse when a request is lost (registered)
//   coins_total : [stats] coins paid, 16-bit wrapping
//   jam_count   : [stats] jams seen, 8-bit saturating
// ---------------------------------------------------------------------------
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  change,
  input  logic        coin_sensed,
  input  logic        clear_jam,
  output logic        coin_out,
  output logic        busy,
  output logic        done,
  output logic        jam,
  output logic        req_drop
`ifdef CHANGE_DISP_STATS_EN
  ,
  output logic [15:0] coins_total,
  output logic [7:0]  jam_count
`endif
);

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYCLES - 1);
  localparam logic [9:0] WAIT_LAST   = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  state_e     state_q, state_d;
  logic [1:0] remaining_q, remaining_d;
  logic [7:0] pulse_cnt_q, pulse_cnt_d;
  logic [9:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] retry_q, retry_d;
  logic       coin_seen_q, coin_seen_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_coins_q, pend_coins_d;
  logic       coin_out_q, coin_out_d;
  logic       done_q, done_d;
  logic       req_drop_q, req_drop_d;

  logic       coin_edge;
  logic       req_valid;
  logic [1:0] req_coins;
  logic       count_coin;
  logic [2:0] retry_next;

  edge_sync u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (coin_sensed),
    .rise     (coin_edge)
  );

  assign req_valid  = is_valid_code(change);
  assign req_coins  = coins_for_code(change);
  assign retry_next = retry_q + 3'd1;
  // Sensor edges only mean something while a coin is being paid out.
  assign count_coin = coin_edge && ((state_q == PULSE) || (state_q == WAIT))
                      && (remaining_q != 2'd0);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pulse_cnt_d  = pulse_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    retry_d      = retry_q;
    coin_seen_d  = coin_seen_q;
    pend_valid_d = pend_valid_q;
    pend_coins_d = pend_coins_q;
    req_drop_d   = 1'b0;

    // Requests arriving while busy go to the one-deep slot or are dropped.
    if (req_valid && (state_q != IDLE)) begin
      if ((state_q == JAM) || pend_valid_q) begin
        req_drop_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_coins_d = req_coins;
      end
    end

    if (count_coin) begin
      remaining_d = remaining_q - 2'd1;
      retry_d     = 3'd0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = PULSE;
          remaining_d = req_coins;
          pulse_cnt_d = 8'd0;
          coin_seen_d = 1'b0;
          retry_d     = 3'd0;
        end
      end

      // The pulse always runs to full length; a coin sensed mid-pulse is
      // remembered and acted on when the pulse ends.
      PULSE: begin
        if (count_coin) begin
          coin_seen_d = 1'b1;
        end
        if (pulse_cnt_q == PULSE_LAST) begin
          pulse_cnt_d = 8'd0;
          if (count_coin || coin_seen_q) begin
            coin_seen_d = 1'b0;
            state_d     = (remaining_d == 2'd0) ? DONE : PULSE;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = 10'd0;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
      end

      // A sensed coin wins over a timeout landing in the same cycle.
      WAIT: begin
        if (count_coin) begin
          state_d     = (remaining_d == 2'd0) ? DONE : PULSE;
          pulse_cnt_d = 8'd0;
          coin_seen_d = 1'b0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = 10'd0;
          retry_d    = retry_next;
          if (retry_next < RETRY_LIMIT) begin
            state_d     = PULSE;
            pulse_cnt_d = 8'd0;
          end else begin
            state_d = JAM;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 10'd1;
        end
      end

      // A new request seen in DONE with an empty slot starts directly,
      // otherwise it would be stranded in the slot once we reach IDLE.
      DONE: begin
        pulse_cnt_d = 8'd0;
        coin_seen_d = 1'b0;
        retry_d     = 3'd0;
        if (pend_valid_q) begin
          state_d      = PULSE;
          remaining_d  = pend_coins_q;
          pend_valid_d = 1'b0;
        end else if (req_valid) begin
          state_d      = PULSE;
          remaining_d  = req_coins;
          pend_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      JAM: begin
        pend_valid_d = 1'b0;
        if (clear_jam) begin
          state_d     = IDLE;
          retry_d     = 3'd0;
          remaining_d = 2'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    coin_out_d = (state_d == PULSE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      remaining_q  <= 2'd0;
      pulse_cnt_q  <= 8'd0;
      wait_cnt_q   <= 10'd0;
      retry_q      <= 3'd0;
      coin_seen_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_coins_q <= 2'd0;
      coin_out_q   <= 1'b0;
      done_q       <= 1'b0;
      req_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      pulse_cnt_q  <= pulse_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      retry_q      <= retry_d;
      coin_seen_q  <= coin_seen_d;
      pend_valid_q <= pend_valid_d;
      pend_coins_q <= pend_coins_d;
      coin_out_q   <= coin_out_d;
      done_q       <= done_d;
      req_drop_q   <= req_drop_d;
    end
  end

  assign coin_out = coin_out_q;
  assign done     = done_q;
  assign req_drop = req_drop_q;
  assign busy     = (state_q != IDLE);
  assign jam      = (state_q == JAM);

`ifdef CHANGE_DISP_STATS_EN
  logic [15:0] coins_total_q, coins_total_d;
  logic [7:0]  jam_count_q, jam_count_d;

  always_comb begin
    coins_total_d = coins_total_q + (count_coin ? 16'd1 : 16'd0);
    jam_count_d   = jam_count_q;
    if ((state_q != JAM) && (state_d == JAM) && (jam_count_q != 8'hFF)) begin
      jam_count_d = jam_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coins_total_q <= 16'd0;
      jam_count_q   <= 8'd0;
    end else begin
      coins_total_q <= coins_total_d;
      jam_count_q   <= jam_count_d;
    end
  end

  assign coins_total = coins_total_q;
  assign jam_count   = jam_count_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
// Directed bench for change_dispenser with default parameters. A small
// hopper model pulses coin_sensed after each eject. Expected done events
// (with the number of eject pulses each request should take) and expected
// req_drop events are queued when requests are driven and consumed by a
// monitor when the DUT raises done / req_drop.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

  localparam int PULSE_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int MAX_RETRY      = 2;

  logic       clk;
  logic       reset;
  logic [1:0] change;
  logic       coin_sensed;
  logic       clear_jam;
  logic       coin_out;
  logic       busy;
  logic       done;
  logic       jam;
  logic       req_drop;
`ifdef CHANGE_DISP_STATS_EN
  logic [15:0] coins_total;
  logic [7:0]  jam_count;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  int    exp_done[$];
  string exp_drop[$];
  int    pulses_since_done = 0;
  int    done_seen = 0;
  logic  prev_coin = 1'b0;

  change_dispenser #(
    .PULSE_CYCLES   (PULSE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .change      (change),
    .coin_sensed (coin_sensed),
    .clear_jam   (clear_jam),
    .coin_out    (coin_out),
    .busy        (busy),
    .done        (done),
    .jam         (jam),
    .req_drop    (req_drop)
`ifdef CHANGE_DISP_STATS_EN
    ,
    .coins_total (coins_total),
    .jam_count   (jam_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present a request code for exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] code);
    change = code;
    @(negedge clk);
    change = 2'b00;
  endtask

  task automatic doReset();
    reset       = 1'b0;
    change      = 2'b00;
    coin_sensed = 1'b0;
    clear_jam   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", int'({coin_out, busy, done, jam, req_drop}), 0);
    exp_done.delete();
    exp_drop.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for coin_out to go high, then returns its high width.
  task automatic measurePulse(output int width);
    int guard;
    guard = 0;
    width = 0;
    while (!coin_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    while (coin_out && width < 300) begin
      width++;
      @(negedge clk);
    end
  endtask

  // Hopper model: one coin passes the exit sensor.
  task automatic hopperCoin();
    coin_sensed = 1'b1;
    repeat (2) @(negedge clk);
    coin_sensed = 1'b0;
  endtask

  // Cycles spent with coin_out low and no jam, i.e. the WAIT window length.
  task automatic measureGap(output int gap);
    gap = 0;
    while (!coin_out && !jam && gap < 500) begin
      gap++;
      @(negedge clk);
    end
  endtask

  task automatic waitDrained(input string tag);
    int guard;
    guard = 0;
    while ((exp_done.size() != 0 || exp_drop.size() != 0) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_drained"}, exp_done.size() + exp_drop.size(), 0);
  endtask

  // Monitor: consumes scoreboard entries when done / req_drop appear.
  initial begin
    int    exp_pulses;
    string drop_tag;
    forever begin
      @(negedge clk);
      if (!reset || jam) begin
        pulses_since_done = 0;
        prev_coin = coin_out;
      end else begin
        if (coin_out && !prev_coin) pulses_since_done++;
        prev_coin = coin_out;
      end
      if (reset && done) begin
        done_seen++;
        checkOutput("done_expected", (exp_done.size() != 0) ? 1 : 0, 1);
        if (exp_done.size() != 0) begin
          exp_pulses = exp_done.pop_front();
          checkOutput("done_pulse_count", pulses_since_done, exp_pulses);
        end
        pulses_since_done = 0;
      end
      if (reset && req_drop) begin
        checkOutput("drop_expected", (exp_drop.size() != 0) ? 1 : 0, 1);
        if (exp_drop.size() != 0) drop_tag = exp_drop.pop_front();
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int width;
    int gap;
    int done_before;
    int activity;

    reset       = 1'b1;
    change      = 2'b00;
    coin_sensed = 1'b0;
    clear_jam   = 1'b0;
    @(negedge clk);

    // --- single 5-unit coin, sensed during WAIT ---
    $display("[TB] test: single coin");
    doReset();
    done_before = done_seen;
    exp_done.push_back(1);
    applyStimulus(2'b01);
    checkOutput("t1_coin_out_first_cycle", int'(coin_out), 1);
    checkOutput("t1_busy", int'(busy), 1);
    measurePulse(width);
    checkOutput("t1_pulse_width", width, PULSE_CYCLES);
    hopperCoin();
    waitDrained("t1");
    repeat (2) @(negedge clk);
    checkOutput("t1_busy_falls", int'(busy), 0);
    checkOutput("t1_done_once", done_seen - done_before, 1);

    // --- 10 units: two coins ---
    $display("[TB] test: two coins");
    doReset();
    exp_done.push_back(2);
    applyStimulus(2'b10);
    measurePulse(width);
    checkOutput("t2_pulse1_width", width, PULSE_CYCLES);
    checkOutput("t2_busy_between", int'(busy), 1);
    hopperCoin();
    measurePulse(width);
    checkOutput("t2_pulse2_width", width, PULSE_CYCLES);
    hopperCoin();
    waitDrained("t2");
    repeat (2) @(negedge clk);
    checkOutput("t2_busy_falls", int'(busy), 0);
`ifdef CHANGE_DISP_STATS_EN
    checkOutput("t2_coins_total", int'(coins_total), 2);
`endif

    // --- hopper never delivers: retries then jam ---
    $display("[TB] test: jam");
    doReset();
    applyStimulus(2'b01);
    measurePulse(width);
    checkOutput("t3_pulse1_width", width, PULSE_CYCLES);
    measureGap(gap);
    checkOutput("t3_wait1_cycles", gap, TIMEOUT_CYCLES);
    measurePulse(width);
    checkOutput("t3_pulse2_width", width, PULSE_CYCLES);
    measureGap(gap);
    checkOutput("t3_wait2_cycles", gap, TIMEOUT_CYCLES);
    checkOutput("t3_jam_set", int'(jam), 1);
    repeat (10) @(negedge clk);
    checkOutput("t3_jam_sticky", int'({jam, coin_out}), 2);
`ifdef CHANGE_DISP_STATS_EN
    checkOutput("t3_jam_count", int'(jam_count), 1);
`endif
    exp_drop.push_back("t3_drop_in_jam");
    applyStimulus(2'b10);
    waitDrained("t3_drop");
    clear_jam = 1'b1;
    @(negedge clk);
    clear_jam = 1'b0;
    checkOutput("t3_jam_cleared", int'({jam, busy}), 0);

    // --- one queued request, one dropped ---
    $display("[TB] test: pending slot");
    doReset();
    exp_done.push_back(1);
    applyStimulus(2'b01);
    exp_done.push_back(2);
    applyStimulus(2'b10);
    exp_drop.push_back("t4_slot_full");
    applyStimulus(2'b01);
    @(negedge clk);
    checkOutput("t4_drop_seen", exp_drop.size(), 0);
    checkOutput("t4_req_drop_one_cycle", int'(req_drop), 0);
    measurePulse(width);
    hopperCoin();
    measurePulse(width);
    checkOutput("t4_queued_pulse1_width", width, PULSE_CYCLES);
    hopperCoin();
    measurePulse(width);
    checkOutput("t4_queued_pulse2_width", width, PULSE_CYCLES);
    hopperCoin();
    waitDrained("t4");
    repeat (2) @(negedge clk);
    checkOutput("t4_busy_falls", int'(busy), 0);

    // --- asynchronous reset in the middle of a pulse ---
    $display("[TB] test: reset mid-pulse");
    doReset();
    applyStimulus(2'b10);
    applyStimulus(2'b01);
    checkOutput("t5_coin_out_before_reset", int'(coin_out), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_async_reset_outputs", int'({coin_out, busy, done, jam, req_drop}), 0);
    @(negedge clk);
    exp_done.delete();
    exp_drop.delete();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t5_idle_after_reset", int'({coin_out, busy}), 0);
    exp_done.push_back(1);
    applyStimulus(2'b01);
    measurePulse(width);
    checkOutput("t5_pulse_width", width, PULSE_CYCLES);
    hopperCoin();
    waitDrained("t5");
    repeat (2) @(negedge clk);
    checkOutput("t5_pending_discarded", int'({coin_out, busy}), 0);

    // --- reserved code, stray sensor pulse and clear_jam while idle ---
    $display("[TB] test: idle ignores");
    doReset();
    activity = 0;
    applyStimulus(2'b11);
    repeat (6) begin
      if (busy || coin_out || done || req_drop || jam) activity++;
      @(negedge clk);
    end
    checkOutput("t6_code11_ignored", activity, 0);
    activity = 0;
    hopperCoin();
    repeat (6) begin
      if (busy || coin_out || done || req_drop || jam) activity++;
      @(negedge clk);
    end
    checkOutput("t6_sensor_ignored", activity, 0);
    clear_jam = 1'b1;
    @(negedge clk);
    clear_jam = 1'b0;
    @(negedge clk);
    checkOutput("t6_clear_jam_ignored", int'({busy, jam}), 0);
`ifdef CHANGE_DISP_STATS_EN
    checkOutput("t6_coins_total_idle", int'(coins_total), 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("final_scoreboard_empty", exp_done.size() + exp_drop.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
